mac_fir_sequencer: RTL and testbench

- Time-multiplexes one signed 16x16 multiply-accumulate unit (A*B+C) across NTAPS taps to implement a direct-form FIR filter on a sample stream.
- Owns the sample delay line, the coefficient store and the tap-sequencing state machine.
- Drives the MAC operands, waits out the MAC pipeline latency, and feeds each result back as C for the next tap.
- Sits between the audio sample source and the MAC16 wrapper; one 32-bit filter output per accepted sample.

---
 rtl/mac_seq_pkg.sv | 9 +
 rtl/fir_delay_line.sv | 39 +++
 rtl/mac_fir_sequencer.sv | 101 ++++++++++
 tb/tb_mac_fir_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared state encoding, width defaults and index-width helper for the FIR sequencer
package mac_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;
  function automatic int tap_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: NTAPS x DW circular sample buffer, newest sample at head
//   clk, reset : clock, synchronous active-high reset (clears head and all entries)
//   push, din  : write din at head+1 and advance head
//   rel, dout  : dout = x[head - rel mod NTAPS]
module fir_delay_line
  import mac_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic [tap_w(NTAPS)-1:0]  rel,
  output logic [DW-1:0]            dout
);
  localparam int TW = tap_w(NTAPS);
  localparam logic [TW:0] N = (TW+1)'(NTAPS);
  logic [DW-1:0] mem [NTAPS];
  logic [TW-1:0] head, wr, rd;
  logic [TW:0] sum;
  // head + NTAPS - rel lies in [1, 2*NTAPS-1], so one conditional subtract wraps it for any NTAPS
  always_comb begin
    wr = head == TW'(NTAPS-1) ? '0 : head + 1'b1;
    sum = {1'b0, head} + N - {1'b0, rel};
    rd = TW'(sum >= N ? sum - N : sum);
    dout = mem[rd];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr] <= din;
      head <= wr;
    end
  end
endmodule

// File: rtl/mac_fir_sequencer.sv
// mac_fir_sequencer: direct-form FIR that time-multiplexes one external A*B+C MAC over NTAPS taps
//   clk, reset                  : clock, synchronous active-high reset
//   s_valid/s_ready/s_data      : input sample stream (accepted only in IDLE)
//   coef_we/coef_addr/coef_data : coefficient write port (honoured only in IDLE)
//   mac_a/mac_b/mac_c           : MAC operands (sample, coefficient, running sum), 0 when idle
//   mac_result                  : MAC output, valid MAC_LATENCY cycles after operands are driven
//   m_valid/m_ready/m_data      : filter output stream, held until handshake
//   busy                        : high whenever not IDLE
module mac_fir_sequencer
  import mac_seq_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int MAC_LATENCY = 2,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DW-1:0]              s_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [DW-1:0]              coef_data,
  output logic [DW-1:0]              mac_a,
  output logic [DW-1:0]              mac_b,
  output logic [AW-1:0]              mac_c,
  input  logic [AW-1:0]              mac_result,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [AW-1:0]              m_data,
  output logic                       busy
);
  localparam int TW = tap_w(NTAPS);
  localparam int WW = tap_w(MAC_LATENCY + 1);
  localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAC_LATENCY - 1);
  state_t state, state_nx;
  logic [TW-1:0] tap;
  logic [WW-1:0] wcnt;
  logic [AW-1:0] acc;
  logic [DW-1:0] coef [NTAPS];
  logic [DW-1:0] x_tap;
  logic accept, wait_done, active;
  assign accept = state == IDLE && s_valid;
  assign wait_done = state == WAIT && wcnt == LAST_WAIT;
  fir_delay_line #(.NTAPS(NTAPS), .DW(DW)) u_dl (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .din  (s_data),
    .rel  (tap),
    .dout (x_tap)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = s_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = !wait_done ? WAIT : tap == LAST_TAP ? DONE : ISSUE;
      DONE:    state_nx = m_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operands come straight from tap/acc, which stay frozen through ISSUE and WAIT
  always_comb begin
    active = state == ISSUE || state == WAIT;
    s_ready = state == IDLE;
    busy = state != IDLE;
    mac_a = active ? x_tap : '0;
    mac_b = active ? coef[tap] : '0;
    mac_c = active ? acc : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tap <= '0;
      wcnt <= '0;
      acc <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      if (state == IDLE && coef_we) coef[coef_addr] <= coef_data;
      if (accept) begin
        tap <= '0;
        acc <= '0;
      end
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (wait_done) begin
        acc <= mac_result;
        if (tap != LAST_TAP) tap <= tap + 1'b1;
        else begin
          m_data <= mac_result;
          m_valid <= 1'b1;
        end
      end
      if (state == DONE && m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_fir_sequencer.sv
// tb_mac_fir_sequencer: scoreboard bench with a behavioural FIR reference model and an external MAC model
module tb_mac_fir_sequencer;
  localparam int NTAPS = 8;
  localparam int L = 2;
  localparam int DW = 16;
  localparam int AW = 32;
  logic clk = 0;
  logic reset = 1;
  logic s_valid = 0;
  logic s_ready;
  logic [DW-1:0] s_data = '0;
  logic coef_we = 0;
  logic [2:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] mac_c, mac_result;
  logic m_valid;
  logic m_ready;
  logic [AW-1:0] m_data;
  logic busy;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_data = '0;
  int h_m [NTAPS];
  int x_m [NTAPS];
  bit rnd = 0;
  bit hold = 1;
  always #5 clk = ~clk;
  mac_fir_sequencer #(.NTAPS(NTAPS), .MAC_LATENCY(L), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_result(mac_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );
  // external MAC: A*B+C through an L-stage pipeline
  logic [AW-1:0] pipe [L];
  int p;
  always @(posedge clk) begin
    p = int'($signed(mac_a)) * int'($signed(mac_b));
    pipe[0] <= 32'(p) + mac_c;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_result = pipe[L-1];
  initial begin
    m_ready = 1;
    forever begin
      @(posedge clk);
      #1 m_ready = rnd ? ($urandom_range(0, 3) != 0) : hold;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got %0h with nothing expected", m_data);
      end else chk("out", m_data, exp_q.pop_front());
      last_data = m_data;
    end
  end
  task automatic clear_model();
    for (int k = 0; k < NTAPS; k++) begin
      h_m[k] = 0;
      x_m[k] = 0;
    end
    exp_q.delete();
  endtask
  task automatic do_reset();
    reset = 1;
    s_valid = 0;
    coef_we = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    clear_model();
  endtask
  task automatic wr_coef(input int a, input int v, input bit applies);
    coef_we = 1;
    coef_addr = 3'(a);
    coef_data = 16'(v);
    @(posedge clk);
    #1 coef_we = 0;
    if (applies) h_m[a] = v;
  endtask
  task automatic send(input int v);
    int n = 0;
    bit got = 0;
    longint s = 0;
    s_valid = 1;
    s_data = 16'(v);
    while (!got && n < 500) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1 n++;
    end
    s_valid = 0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no s_ready expected within 500 cycles");
    end else begin
      for (int k = NTAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
      x_m[0] = v;
      for (int k = 0; k < NTAPS; k++) s += longint'(h_m[k]) * longint'(x_m[k]);
      exp_q.push_back(s[31:0]);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, seen, v;
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mac_a", 32'(mac_a), 0);
    chk("rst_mac_b", 32'(mac_b), 0);
    chk("rst_mac_c", mac_c, 0);
    // single-tap identity, latency measurement
    wr_coef(0, 1, 1);
    send(100);
    @(negedge clk);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_s_ready", 32'(s_ready), 0);
    chk("issue_mac_a", 32'(mac_a), 100);
    chk("issue_mac_b", 32'(mac_b), 1);
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 32'(n), 24);
    drain();
    chk("identity_out", last_data, 100);
    // impulse response through h[k]=k+1
    do_reset();
    for (int k = 0; k < NTAPS; k++) wr_coef(k, k + 1, 1);
    send(1);
    for (int k = 0; k < 8; k++) send(0);
    drain();
    chk("impulse_tail", last_data, 0);
    // signed coefficients
    do_reset();
    wr_coef(0, -5, 1);
    wr_coef(1, 3, 1);
    send(3);
    drain();
    chk("signed_first", last_data, 32'(-15));
    send(-4);
    drain();
    chk("signed_second", last_data, 29);
    // output backpressure with a pending sample
    hold = 0;
    send(5);
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("stall_reached", 32'(m_valid), 1);
    d = m_data;
    s_valid = 1;
    s_data = 16'(55);
    repeat (10) begin
      @(negedge clk);
      chk("stall_data", m_data, d);
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_s_ready", 32'(s_ready), 0);
    end
    @(posedge clk);
    #1 s_valid = 0;
    hold = 1;
    drain();
    send(2);
    drain();
    // wrap-around without saturation
    do_reset();
    for (int k = 0; k < NTAPS; k++) wr_coef(k, -32768, 1);
    for (int k = 0; k < 8; k++) send(-32768);
    drain();
    chk("wrap_out", last_data, 0);
    // coefficient write while busy is dropped
    do_reset();
    wr_coef(0, 4, 1);
    send(10);
    wr_coef(0, 999, 0);
    drain();
    send(1);
    drain();
    // coefficient write in the same cycle as a sample takes effect for it
    coef_we = 1;
    coef_addr = 3'd1;
    coef_data = 16'(6);
    h_m[1] = 6;
    send(3);
    coef_we = 0;
    drain();
    chk("same_cycle_coef", last_data, 18);
    // reset in the middle of a computation
    send(9);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    clear_model();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 0);
    chk("abort_idle", 32'(busy), 0);
    wr_coef(0, 2, 1);
    send(7);
    drain();
    chk("after_abort", last_data, 14);
    // randomized traffic with random backpressure
    rnd = 1;
    repeat (3) begin
      for (int k = 0; k < NTAPS; k++) wr_coef(k, int'($signed(16'($urandom))), 1);
      repeat (8) begin
        v = int'($signed(16'($urandom)));
        send(v);
        if ($urandom_range(0, 1) == 1) wr_coef(int'($urandom_range(0, NTAPS - 1)), int'($signed(16'($urandom))), 0);
      end
      drain();
    end
    rnd = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
